// File: rtl/dmem_port_arbiter_if.sv
// Data-memory port bundle: pipeline side, debug burst engine side
// and the shared data_mem port.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 12
);
  logic [ADDR_W-1:0] pipe_address;
  logic [DATA_W-1:0] pipe_in_data;
  logic              pipe_MemWrite;
  logic              pipe_MemRead;
  logic [DATA_W-1:0] pipe_out_data;

  logic              dbg_start;
  logic              dbg_mode;
  logic [ADDR_W-1:0] dbg_addr;
  logic [LEN_W-1:0]  dbg_len;
  logic [DATA_W-1:0] dbg_fill;
  logic              dbg_busy;
  logic              dbg_done;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_valid;
  logic              dbg_ready;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_in_data;
  logic              mem_MemWrite;
  logic              mem_MemRead;
  logic [DATA_W-1:0] mem_out_data;

  modport slave (
    input  pipe_address, pipe_in_data,
    input  pipe_MemWrite, pipe_MemRead,
    output pipe_out_data,
    input  dbg_start, dbg_mode, dbg_addr,
    input  dbg_len, dbg_fill, dbg_ready,
    output dbg_busy, dbg_done, dbg_data, dbg_valid,
    output mem_address, mem_in_data,
    output mem_MemWrite, mem_MemRead,
    input  mem_out_data
  );

  modport master (
    output pipe_address, pipe_in_data,
    output pipe_MemWrite, pipe_MemRead,
    input  pipe_out_data,
    output dbg_start, dbg_mode, dbg_addr,
    output dbg_len, dbg_fill, dbg_ready,
    input  dbg_busy, dbg_done, dbg_data, dbg_valid,
    input  mem_address, mem_in_data,
    input  mem_MemWrite, mem_MemRead,
    output mem_out_data
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the data_mem port between the MEM stage (absolute priority,
// zero-latency) and a debug burst engine that dumps or fills a region.
module dmem_port_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 12
) (
  input logic clock,
  input logic reset,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  rem;
  logic              mode;
  logic [DATA_W-1:0] fill;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              done, done_n;

  logic pipe_act;
  logic fill_iss;
  logic rd_iss;
  logic iss;
  logic last;

  assign pipe_act = bus.pipe_MemRead | bus.pipe_MemWrite;
  assign fill_iss = (state == RUN) && mode && !pipe_act;
  // a read may only issue if its result has somewhere to land
  assign rd_iss = (state == RUN) && !mode && !pipe_act
               && (!valid || bus.dbg_ready);
  assign iss  = fill_iss | rd_iss;
  assign last = (rem == LEN_W'(1));

  always_comb begin
    bus.mem_address  = bus.pipe_address;
    bus.mem_in_data  = bus.pipe_in_data;
    bus.mem_MemWrite = bus.pipe_MemWrite;
    bus.mem_MemRead  = bus.pipe_MemRead;
    if (fill_iss) begin
      bus.mem_address  = addr;
      bus.mem_in_data  = fill;
      bus.mem_MemWrite = 1'b1;
    end else if (rd_iss) begin
      bus.mem_address = addr;
      bus.mem_MemRead = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.dbg_start) begin
          if (bus.dbg_len == '0) done_n = 1'b1;
          else state_n = RUN;
        end
      end
      RUN: begin
        if (iss && last) begin
          if (mode) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (bus.dbg_ready) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      addr  <= '0;
      rem   <= '0;
      mode  <= 1'b0;
      fill  <= '0;
      data  <= '0;
      valid <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= done_n;
      if (state == IDLE && bus.dbg_start) begin
        addr <= bus.dbg_addr;
        rem  <= bus.dbg_len;
        mode <= bus.dbg_mode;
        fill <= bus.dbg_fill;
      end else if (iss) begin
        addr <= addr + ADDR_W'(1);
        rem  <= rem - LEN_W'(1);
      end
      if (rd_iss) begin
        data  <= bus.mem_out_data;
        valid <= 1'b1;
      end else if (valid && bus.dbg_ready) begin
        valid <= 1'b0;
      end
    end
  end

  assign bus.pipe_out_data = bus.mem_out_data;
  assign bus.dbg_busy      = (state != IDLE);
  assign bus.dbg_done      = done;
  assign bus.dbg_data      = data;
  assign bus.dbg_valid     = valid;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: behavioural data_mem plus scoreboard
// queues for debug writes, dumped words and pipeline loads.
module tb_dmem_port_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int LW = 12;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  logic [DW-1:0] mem [0:2047];
  logic [DW-1:0] rdata;

  always @(posedge clock)
    if (bus.mem_MemWrite) mem[bus.mem_address] <= bus.mem_in_data;

  always @(negedge clock)
    if (bus.mem_MemRead) rdata <= mem[bus.mem_address];

  assign bus.mem_out_data = rdata;

  int vectors = 0;
  int errors  = 0;

  logic [AW+DW-1:0] wq [$];
  logic [DW-1:0]    dq [$];
  logic [DW-1:0]    rq [$];

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic pipe_store(input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    bus.pipe_address  = a;
    bus.pipe_in_data  = d;
    bus.pipe_MemWrite = 1'b1;
    @(posedge clock); #1;
    bus.pipe_MemWrite = 1'b0;
    bus.pipe_in_data  = '0;
  endtask

  task automatic pipe_load(input logic [AW-1:0] a,
                           output logic [DW-1:0] d);
    bus.pipe_address = a;
    bus.pipe_MemRead = 1'b1;
    @(negedge clock); #1;
    d = bus.pipe_out_data;
    @(posedge clock); #1;
    bus.pipe_MemRead = 1'b0;
  endtask

  task automatic run_burst(input logic m, input logic [AW-1:0] a,
                           input logic [LW-1:0] n,
                           input logic [DW-1:0] f, input int stall,
                           input bit contend, input bit restart);
    int dones = 0, done_cyc = -1, hs_cyc = -1;
    int st = 0, tail = 0, rdn = 0, exp_rd;
    bit seen = 0, held_ok = 0;
    logic [DW-1:0] held = '0;
    logic [DW-1:0] ed;
    logic [AW+DW-1:0] ew;
    logic pact;
    bus.dbg_mode = m;
    bus.dbg_addr = a;
    bus.dbg_len  = n;
    bus.dbg_fill = f;
    bus.pipe_address = 11'd600;
    for (int c = 0; c < 60; c++) begin
      bus.dbg_start = (c == 0) || (restart && c == 3);
      if (restart && c == 3) begin
        bus.dbg_addr = a + 11'd300;
        bus.dbg_len  = n + 12'd5;
        bus.dbg_fill = ~f;
        bus.dbg_mode = ~m;
      end
      bus.pipe_MemRead = contend && (c % 2 == 0);
      if (bus.dbg_valid && !seen) begin
        seen = 1;
        st = stall;
      end
      bus.dbg_ready = (st == 0);
      if (st > 0) st--;
      @(negedge clock); #1;
      pact = bus.pipe_MemRead | bus.pipe_MemWrite;
      if (pact) begin
        vectors++;
        if (bus.mem_address !== bus.pipe_address ||
            bus.mem_in_data !== bus.pipe_in_data ||
            bus.mem_MemWrite !== bus.pipe_MemWrite ||
            bus.mem_MemRead !== bus.pipe_MemRead) begin
          errors++;
          $display("FAIL pipe_mirror c=%0d: got a=%0d w=%b r=%b want a=%0d w=%b r=%b",
                   c, bus.mem_address, bus.mem_MemWrite, bus.mem_MemRead,
                   bus.pipe_address, bus.pipe_MemWrite, bus.pipe_MemRead);
        end
      end else begin
        if (bus.mem_MemRead) rdn++;
        if (bus.mem_MemWrite) begin
          vectors++;
          if (wq.size() == 0) begin
            errors++;
            $display("FAIL extra_write c=%0d: got a=%0d d=%h want none",
                     c, bus.mem_address, bus.mem_in_data);
          end else begin
            ew = wq.pop_front();
            if ({bus.mem_address, bus.mem_in_data} !== ew) begin
              errors++;
              $display("FAIL dbg_write c=%0d: got a=%0d d=%h want a=%0d d=%h",
                       c, bus.mem_address, bus.mem_in_data,
                       ew[AW+DW-1:DW], ew[DW-1:0]);
            end
          end
        end
      end
      if (n == '0) begin
        vectors++;
        if (bus.dbg_busy !== 1'b0) begin
          errors++;
          $display("FAIL zero_busy c=%0d: got %b want 0", c, bus.dbg_busy);
        end
      end
      if (bus.dbg_valid && bus.dbg_ready) begin
        vectors++;
        hs_cyc = c;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL extra_word c=%0d: got %h want none", c, bus.dbg_data);
        end else begin
          ed = dq.pop_front();
          if (bus.dbg_data !== ed) begin
            errors++;
            $display("FAIL dump_word c=%0d: got %h want %h",
                     c, bus.dbg_data, ed);
          end
        end
      end
      if (bus.dbg_valid && !bus.dbg_ready) begin
        if (held_ok) begin
          vectors++;
          if (bus.dbg_data !== held) begin
            errors++;
            $display("FAIL hold_stable c=%0d: got %h want %h",
                     c, bus.dbg_data, held);
          end
        end
        held = bus.dbg_data;
        held_ok = 1;
      end else begin
        held_ok = 0;
      end
      if (bus.dbg_done) begin
        dones++;
        done_cyc = c;
      end
      @(posedge clock); #1;
      if (dones > 0 && !bus.dbg_busy) tail++;
      if (tail >= 3) break;
    end
    bus.dbg_start    = 1'b0;
    bus.pipe_MemRead = 1'b0;
    bus.dbg_ready    = 1'b1;
    exp_rd = m ? 0 : int'(n);
    vectors++;
    if (dones != 1) begin
      errors++;
      $display("FAIL done_count: got %0d want 1", dones);
    end
    vectors++;
    if (wq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL missing_items: got w=%0d d=%0d left want 0 0",
               wq.size(), dq.size());
    end
    vectors++;
    if (rdn != exp_rd) begin
      errors++;
      $display("FAIL read_issues: got %0d want %0d", rdn, exp_rd);
    end
    vectors++;
    if (bus.dbg_busy !== 1'b0 || bus.dbg_valid !== 1'b0) begin
      errors++;
      $display("FAIL end_idle: got busy=%b valid=%b want 0 0",
               bus.dbg_busy, bus.dbg_valid);
    end
    if (!m && n != '0) begin
      vectors++;
      if (done_cyc != hs_cyc + 1) begin
        errors++;
        $display("FAIL done_timing: got cycle %0d want %0d",
                 done_cyc, hs_cyc + 1);
      end
    end
    wq.delete();
    dq.delete();
  endtask

  task automatic test_reset();
    bus.pipe_address = 11'd7;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock); #1;
    vectors++;
    if ({bus.dbg_busy, bus.dbg_done, bus.dbg_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b%b%b want 000",
               bus.dbg_busy, bus.dbg_done, bus.dbg_valid);
    end
    vectors++;
    if (bus.dbg_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", bus.dbg_data);
    end
    vectors++;
    if (bus.mem_MemRead !== 1'b0 || bus.mem_MemWrite !== 1'b0 ||
        bus.mem_address !== 11'd7) begin
      errors++;
      $display("FAIL idle_port: got r=%b w=%b a=%0d want 0 0 7",
               bus.mem_MemRead, bus.mem_MemWrite, bus.mem_address);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_passthrough();
    logic [DW-1:0] d, e;
    bus.pipe_address  = 11'd5;
    bus.pipe_in_data  = 32'hDEADBEEF;
    bus.pipe_MemWrite = 1'b1;
    rq.push_back(32'hDEADBEEF);
    @(negedge clock); #1;
    vectors++;
    if (bus.mem_address !== 11'd5 || bus.mem_in_data !== 32'hDEADBEEF ||
        bus.mem_MemWrite !== 1'b1 || bus.mem_MemRead !== 1'b0) begin
      errors++;
      $display("FAIL pass_store: got a=%0d d=%h w=%b r=%b want 5 deadbeef 1 0",
               bus.mem_address, bus.mem_in_data,
               bus.mem_MemWrite, bus.mem_MemRead);
    end
    @(posedge clock); #1;
    bus.pipe_MemWrite = 1'b0;
    bus.pipe_in_data  = '0;
    bus.pipe_MemRead  = 1'b1;
    @(negedge clock); #1;
    vectors++;
    if (bus.mem_address !== 11'd5 || bus.mem_MemRead !== 1'b1 ||
        bus.mem_MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL pass_load: got a=%0d r=%b w=%b want 5 1 0",
               bus.mem_address, bus.mem_MemRead, bus.mem_MemWrite);
    end
    d = bus.pipe_out_data;
    e = rq.pop_front();
    vectors++;
    if (d !== e) begin
      errors++;
      $display("FAIL pass_rdata: got %h want %h", d, e);
    end
    @(posedge clock); #1;
    bus.pipe_MemRead = 1'b0;
  endtask

  task automatic test_fill_contention();
    logic [DW-1:0] d, e;
    pipe_store(11'd14, 32'h14141414);
    for (int i = 10; i < 14; i++) wq.push_back({AW'(i), 32'hA5A5A5A5});
    run_burst(1'b1, 11'd10, 12'd4, 32'hA5A5A5A5, 0, 1'b1, 1'b0);
    for (int i = 10; i < 15; i++) begin
      rq.push_back(i == 14 ? 32'h14141414 : 32'hA5A5A5A5);
      pipe_load(AW'(i), d);
      e = rq.pop_front();
      vectors++;
      if (d !== e) begin
        errors++;
        $display("FAIL fill_readback[%0d]: got %h want %h", i, d, e);
      end
    end
  endtask

  task automatic test_dump_backpressure();
    pipe_store(11'd100, 32'd1);
    pipe_store(11'd101, 32'd2);
    pipe_store(11'd102, 32'd3);
    dq.push_back(32'd1);
    dq.push_back(32'd2);
    dq.push_back(32'd3);
    run_burst(1'b0, 11'd100, 12'd3, '0, 3, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_zero();
    logic [DW-1:0] d, e;
    logic [AW-1:0] ra [3];
    ra[0] = 11'd2046;
    ra[1] = 11'd2047;
    ra[2] = 11'd0;
    for (int i = 0; i < 3; i++) wq.push_back({ra[i], 32'h5A5A0001});
    run_burst(1'b1, 11'd2046, 12'd3, 32'h5A5A0001, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rq.push_back(32'h5A5A0001);
      pipe_load(ra[i], d);
      e = rq.pop_front();
      vectors++;
      if (d !== e) begin
        errors++;
        $display("FAIL wrap_readback[%0d]: got %h want %h", ra[i], d, e);
      end
    end
    run_burst(1'b1, 11'd50, 12'd0, 32'hFFFFFFFF, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int iss = 0, dn = 0;
    bus.dbg_mode  = 1'b0;
    bus.dbg_addr  = 11'd100;
    bus.dbg_len   = 12'd8;
    bus.dbg_ready = 1'b1;
    bus.dbg_start = 1'b1;
    for (int c = 0; c < 20 && iss < 3; c++) begin
      @(negedge clock); #1;
      if (bus.mem_MemRead) iss++;
      @(posedge clock); #1;
      bus.dbg_start = 1'b0;
    end
    vectors++;
    if (iss != 3) begin
      errors++;
      $display("FAIL rst_issues: got %0d want 3", iss);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock); #1;
    vectors++;
    if ({bus.dbg_busy, bus.dbg_valid, bus.dbg_done} !== 3'b000 ||
        bus.dbg_data !== '0) begin
      errors++;
      $display("FAIL rst_mid: got b=%b v=%b d=%b data=%h want 0 0 0 0",
               bus.dbg_busy, bus.dbg_valid, bus.dbg_done, bus.dbg_data);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      @(negedge clock); #1;
      if (bus.dbg_done) dn++;
    end
    vectors++;
    if (dn != 0) begin
      errors++;
      $display("FAIL rst_no_done: got %0d pulses want 0", dn);
    end
    @(posedge clock); #1;
    dq.push_back(32'd1);
    dq.push_back(32'd2);
    dq.push_back(32'd3);
    run_burst(1'b0, 11'd100, 12'd3, '0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_start_busy();
    for (int i = 400; i < 404; i++) wq.push_back({AW'(i), 32'h12345678});
    run_burst(1'b1, 11'd400, 12'd4, 32'h12345678, 0, 1'b0, 1'b1);
  endtask

  initial begin
    bus.pipe_address  = '0;
    bus.pipe_in_data  = '0;
    bus.pipe_MemWrite = 1'b0;
    bus.pipe_MemRead  = 1'b0;
    bus.dbg_start     = 1'b0;
    bus.dbg_mode      = 1'b0;
    bus.dbg_addr      = '0;
    bus.dbg_len       = '0;
    bus.dbg_fill      = '0;
    bus.dbg_ready     = 1'b1;
    test_reset();
    test_passthrough();
    test_fill_contention();
    test_dump_backpressure();
    test_wrap_zero();
    test_reset_mid();
    test_start_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
